multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max wait cycles on imem_ready/dmem_ready before trap.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port instr  input  32  IR contents, valid from DECODE onward.
REQ-005 SHALL have port imem_ready  input  1  instruction memory data valid.
REQ-006 SHALL have port dmem_ready  input  1  data memory access complete.
REQ-007 SHALL have port branch_taken  input  1  ALU compare result for current SB instruction.
REQ-008 SHALL have port imem_req  output  1  fetch request.
REQ-009 SHALL have port dmem_req, dmem_we  output  1 each  data access request, write enable.
REQ-010 SHALL have port ir_we, pc_we, reg_we  output  1 each  IR, PC, regfile write enables.
REQ-011 SHALL have port pc_sel  output  2  PC source: 0 PC+4, 1 PC+imm, 2 ALU result (JALR).
REQ-012 SHALL have port imm_sel  output  3  immediate format select to immediate generator.
REQ-013 SHALL have port alu_src_b  output  1  0 rs2, 1 immediate.
REQ-014 SHALL have port alu_op  output  2  0 add, 1 branch compare, 2 funct-decoded.
REQ-015 SHALL have port wb_sel  output  2  0 ALU, 1 load data, 2 PC+4, 3 immediate (LUI).
REQ-016 SHALL have port state  output  3  current FSM state; trap  output  1  sticky fault flag.

Function
REQ-017 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
REQ-018 FETCH: imem_req=1 held until imem_ready; on imem_ready same cycle ir_we=1, pc_we=1, pc_sel=0, next DECODE.
REQ-019 DECODE: one cycle; opcode instr[6:0] in {0110011 R, 0010011 I, 0000011 LOAD, 0100011 S, 1100011 SB, 1101111 JAL, 1100111 JALR, 0110111 LUI} -> EXECUTE; any other opcode -> TRAP.
REQ-020 imm_sel SHALL be driven from decoded opcode in DECODE, EXECUTE, MEM, WB: I/LOAD/JALR=I, S=S, SB=B, JAL=J, LUI=U, R=I (don't care).
REQ-021 EXECUTE R/I/LUI: alu_op=2 (LUI 0), alu_src_b=0 for R else 1, next WB.
REQ-022 EXECUTE LOAD/S: alu_op=0, alu_src_b=1, next MEM.
REQ-023 EXECUTE SB: alu_op=1; if branch_taken then pc_we=1, pc_sel=1; next FETCH.
REQ-024 EXECUTE JAL: pc_we=1, pc_sel=1; JALR: alu_src_b=1, pc_we=1, pc_sel=2; both next WB with wb_sel=2.
REQ-025 MEM: dmem_req=1, dmem_we=1 for S, held until dmem_ready; on dmem_ready S -> FETCH, LOAD -> WB.
REQ-026 WB: reg_we=1 for one cycle, wb_sel per REQ-015, next FETCH.
REQ-027 All enables/requests SHALL be zero in states and cycles not listed; outputs are Moore except ir_we/pc_we in FETCH and pc_we in EXECUTE SB (combinational on ready/branch_taken).
REQ-028 Wait counter SHALL clear on entry to FETCH/MEM and increment each cycle ready is low; ready seen on cycle TIMEOUT still completes; counter reaching TIMEOUT+1 -> TRAP.
REQ-029 TRAP SHALL be absorbing until reset; trap=1, all enables 0.
REQ-030 Zero-wait latency SHALL be: R/I/LUI/JAL/JALR 4 cycles, LOAD 5, S 4, SB 3.
REQ-031 instr changes outside ir_we SHALL NOT alter decoded control (opcode class registered in DECODE).

Reset
REQ-032 n_rst low SHALL asynchronously force state=FETCH, counter=0, trap=0, decoded class=R; all outputs 0 except state.
REQ-033 Reset mid-MEM SHALL drop dmem_req immediately; first post-reset cycle issues imem_req=1.

Structure
REQ-034 Package rv_ctrl_pkg SHALL hold opcode constants, state enum, imm_sel/pc_sel/wb_sel/alu_op encodings.
REQ-035 One sub-module opcode_decode (combinational opcode -> class/imm_sel/legal) SHALL be instantiated.

Verification
REQ-036 R-type 0x002081B3, imem_ready=1 always -> states FETCH,DECODE,EXECUTE,WB; reg_we=1 cycle 4 only, wb_sel=0.
REQ-037 LOAD 0x0000A103, dmem_ready low 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB wb_sel=1.
REQ-038 SB 0x00208463 with branch_taken=1 -> EXECUTE pc_we=1, pc_sel=1; branch_taken=0 -> pc_we=0; both return FETCH after 3 cycles.
REQ-039 instr opcode 0x7F -> TRAP after DECODE, trap=1 sticky; n_rst pulse -> FETCH, trap=0.
REQ-040 imem_ready held low -> TRAP after TIMEOUT+1 wait cycles; ready on cycle TIMEOUT -> DECODE, no trap.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control FSM and its opcode decoder.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_SB   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LOAD = 3'd2,
        CLS_S    = 3'd3,
        CLS_SB   = 3'd4,
        CLS_JAL  = 3'd5,
        CLS_JALR = 3'd6,
        CLS_LUI  = 3'd7
    } instr_class_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_BRANCH = 2'd1,
        ALU_FUNCT  = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    // Immediate format each instruction class feeds to the immediate generator
    function automatic imm_sel_e class_imm_sel(input instr_class_e cls);
        imm_sel_e sel;
        case (cls)
            CLS_S:   sel = IMM_S;
            CLS_SB:  sel = IMM_B;
            CLS_JAL: sel = IMM_J;
            CLS_LUI: sel = IMM_U;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: instruction class, immediate format and legality.
module opcode_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output instr_class_e cls_o,
    output imm_sel_e     imm_sel_o,
    output logic         legal_o
);

    // Map the 7-bit opcode onto one of the supported classes; anything else is illegal
    always_comb begin
        cls_o   = CLS_R;
        legal_o = 1'b1;
        case (opcode_i)
            OPC_R:    cls_o = CLS_R;
            OPC_I:    cls_o = CLS_I;
            OPC_LOAD: cls_o = CLS_LOAD;
            OPC_S:    cls_o = CLS_S;
            OPC_SB:   cls_o = CLS_SB;
            OPC_JAL:  cls_o = CLS_JAL;
            OPC_JALR: cls_o = CLS_JALR;
            OPC_LUI:  cls_o = CLS_LUI;
            default:  legal_o = 1'b0;
        endcase
        imm_sel_o = class_imm_sel(cls_o);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback with ready timeouts and a sticky trap.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
)
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        trap
);

    localparam int            CW      = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_e        state_q,      state_d;
    instr_class_e  instrClass_q, instrClass_d;
    logic [CW-1:0] waitCnt_q,    waitCnt_d;

    instr_class_e  decClass;
    imm_sel_e      decImm;
    logic          decLegal;
    logic          unused_instr_bits;

    assign unused_instr_bits = ^instr[31:7];

    opcode_decode u_opcode_decode (
        .opcode_i  (instr[6:0]),
        .cls_o     (decClass),
        .imm_sel_o (decImm),
        .legal_o   (decLegal)
    );

    // State, registered instruction class and ready-wait counter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_FETCH;
            instrClass_q <= CLS_R;
            waitCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            instrClass_q <= instrClass_d;
            waitCnt_q    <= waitCnt_d;
        end
    end

    // Next state and control outputs; everything idles at zero while reset is held
    always_comb begin
        state_d      = state_q;
        instrClass_d = instrClass_q;
        waitCnt_d    = '0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        reg_we       = 1'b0;
        pc_sel       = PC_PLUS4;
        imm_sel      = IMM_I;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        wb_sel       = WB_ALU;
        trap         = 1'b0;
        if (n_rst) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        pc_sel  = PC_PLUS4;
                        state_d = ST_DECODE;
                    end else if (waitCnt_q == CNT_MAX) begin
                        state_d = ST_TRAP;
                    end else begin
                        waitCnt_d = waitCnt_q + 1'b1;
                    end
                end
                ST_DECODE: begin
                    imm_sel = decImm;
                    if (decLegal) begin
                        instrClass_d = decClass;
                        state_d      = ST_EXECUTE;
                    end else begin
                        state_d = ST_TRAP;
                    end
                end
                ST_EXECUTE: begin
                    imm_sel = class_imm_sel(instrClass_q);
                    case (instrClass_q)
                        CLS_R: begin
                            alu_op  = ALU_FUNCT;
                            state_d = ST_WB;
                        end
                        CLS_I: begin
                            alu_op    = ALU_FUNCT;
                            alu_src_b = 1'b1;
                            state_d   = ST_WB;
                        end
                        CLS_LUI: begin
                            alu_src_b = 1'b1;
                            state_d   = ST_WB;
                        end
                        CLS_LOAD, CLS_S: begin
                            alu_src_b = 1'b1;
                            state_d   = ST_MEM;
                        end
                        CLS_SB: begin
                            alu_op = ALU_BRANCH;
                            if (branch_taken) begin
                                pc_we  = 1'b1;
                                pc_sel = PC_IMM;
                            end
                            state_d = ST_FETCH;
                        end
                        CLS_JAL: begin
                            pc_we   = 1'b1;
                            pc_sel  = PC_IMM;
                            state_d = ST_WB;
                        end
                        CLS_JALR: begin
                            alu_src_b = 1'b1;
                            pc_we     = 1'b1;
                            pc_sel    = PC_ALU;
                            state_d   = ST_WB;
                        end
                        default: state_d = ST_TRAP;
                    endcase
                end
                ST_MEM: begin
                    imm_sel  = class_imm_sel(instrClass_q);
                    dmem_req = 1'b1;
                    dmem_we  = (instrClass_q == CLS_S);
                    if (dmem_ready) begin
                        state_d = (instrClass_q == CLS_S) ? ST_FETCH : ST_WB;
                    end else if (waitCnt_q == CNT_MAX) begin
                        state_d = ST_TRAP;
                    end else begin
                        waitCnt_d = waitCnt_q + 1'b1;
                    end
                end
                ST_WB: begin
                    imm_sel = class_imm_sel(instrClass_q);
                    reg_we  = 1'b1;
                    case (instrClass_q)
                        CLS_LOAD:          wb_sel = WB_LOAD;
                        CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                        CLS_LUI:           wb_sel = WB_IMM;
                        default:           wb_sel = WB_ALU;
                    endcase
                    state_d = ST_FETCH;
                end
                ST_TRAP: begin
                    trap = 1'b1;
                end
                default: state_d = ST_TRAP;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized instruction traces.
module tb_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    localparam int TO = 15;

    typedef struct packed {
        logic [2:0] st;
        logic       trp;
        logic       ireq;
        logic       dreq;
        logic       dwe;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic [1:0] pcs;
        logic [2:0] imm;
        logic       sb;
        logic [1:0] aop;
        logic [1:0] wb;
    } outs_t;

    typedef struct packed {
        outs_t       exp;
        logic [31:0] ins;
        logic        ir;
        logic        dr;
        logic        bt;
    } cyc_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] instr;
    logic        imem_ready, dmem_ready, branch_taken;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_sel;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        trap;

    int   errors = 0;
    int   checks = 0;
    cyc_t trace[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .instr        (instr),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .reg_we       (reg_we),
        .pc_sel       (pc_sel),
        .imm_sel      (imm_sel),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .wb_sel       (wb_sel),
        .state        (state),
        .trap         (trap)
    );

    // Snapshot of every DUT output in one comparable record
    function automatic outs_t obs();
        outs_t o;
        o.st   = state;
        o.trp  = trap;
        o.ireq = imem_req;
        o.dreq = dmem_req;
        o.dwe  = dmem_we;
        o.irw  = ir_we;
        o.pcw  = pc_we;
        o.rw   = reg_we;
        o.pcs  = pc_sel;
        o.imm  = imm_sel;
        o.sb   = alu_src_b;
        o.aop  = alu_op;
        o.wb   = wb_sel;
        return o;
    endfunction

    // Class index 0..7 = R, I, LOAD, S, SB, JAL, JALR, LUI
    function automatic logic [6:0] model_opc(input int c);
        case (c)
            0:       return 7'b0110011;
            1:       return 7'b0010011;
            2:       return 7'b0000011;
            3:       return 7'b0100011;
            4:       return 7'b1100011;
            5:       return 7'b1101111;
            6:       return 7'b1100111;
            default: return 7'b0110111;
        endcase
    endfunction

    function automatic logic [2:0] model_imm(input int c);
        case (c)
            3:       return IMM_S;
            4:       return IMM_B;
            5:       return IMM_J;
            7:       return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

    function automatic logic [1:0] model_wb(input int c);
        case (c)
            2:       return 2'd1;
            5, 6:    return 2'd2;
            7:       return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic void push_cyc(input outs_t e, input logic [31:0] ins,
                                     input logic ir, input logic dr, input logic bt);
        cyc_t c;
        c.exp = e;
        c.ins = ins;
        c.ir  = ir;
        c.dr  = dr;
        c.bt  = bt;
        trace.push_back(c);
    endfunction

    // Expected per-cycle trace for one instruction given fetch delay, memory delay and branch outcome
    function automatic void model_instr(input int c, input logic [31:0] ins, input int fd,
                                        input int md, input logic taken);
        outs_t e;
        for (int i = 0; i < fd; i++) begin
            e = '0; e.st = ST_FETCH; e.ireq = 1'b1;
            push_cyc(e, $urandom, 1'b0, 1'($urandom), 1'($urandom));
        end
        e = '0; e.st = ST_FETCH; e.ireq = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        push_cyc(e, ins, 1'b1, 1'($urandom), 1'($urandom));
        e = '0; e.st = ST_DECODE; e.imm = model_imm(c);
        push_cyc(e, ins, 1'($urandom), 1'($urandom), 1'($urandom));
        e = '0; e.st = ST_EXECUTE; e.imm = model_imm(c);
        case (c)
            0:    e.aop = 2'd2;
            1:    begin e.aop = 2'd2; e.sb = 1'b1; end
            2, 3: e.sb = 1'b1;
            4:    begin e.aop = 2'd1; e.pcw = taken; e.pcs = taken ? 2'd1 : 2'd0; end
            5:    begin e.pcw = 1'b1; e.pcs = 2'd1; end
            6:    begin e.sb = 1'b1; e.pcw = 1'b1; e.pcs = 2'd2; end
            default: e.sb = 1'b1;
        endcase
        push_cyc(e, $urandom, 1'($urandom), 1'($urandom), (c == 4) ? taken : 1'($urandom));
        if (c == 2 || c == 3) begin
            for (int i = 0; i <= md; i++) begin
                e = '0; e.st = ST_MEM; e.imm = model_imm(c); e.dreq = 1'b1; e.dwe = (c == 3);
                push_cyc(e, $urandom, 1'($urandom), (i == md), 1'($urandom));
            end
        end
        if (c != 3 && c != 4) begin
            e = '0; e.st = ST_WB; e.imm = model_imm(c); e.rw = 1'b1; e.wb = model_wb(c);
            push_cyc(e, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endfunction

    // Hold reset for two edges and release just after a rising edge
    task automatic do_reset();
        n_rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        outs_t e;
        e = '0; e.st = ST_FETCH;
        n_rst = 1'b0; instr = 32'h002081B3;
        imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
        #2;
        checks++;
        if (obs() !== e) begin errors++; $display("[TB] FAIL reset_async: got %h expected %h", obs(), e); end
        @(posedge clk); #1;
        checks++;
        if (obs() !== e) begin errors++; $display("[TB] FAIL reset_held: got %h expected %h", obs(), e); end
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== ST_FETCH || imem_req !== 1'b1 || ir_we !== 1'b1)
            begin errors++; $display("[TB] FAIL reset_first_fetch: state=%0d imem_req=%b ir_we=%b expected 0 1 1", state, imem_req, ir_we); end
    endtask

    task automatic test_rtype();
        logic [2:0] expSt [5];
        logic       expRw [5];
        expSt = '{ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WB, ST_FETCH};
        expRw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        instr = 32'h002081B3; imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (state !== expSt[i] || reg_we !== expRw[i])
                begin errors++; $display("[TB] FAIL rtype_cycle%0d: state=%0d reg_we=%b expected %0d %b", i, state, reg_we, expSt[i], expRw[i]); end
            if (i == 3) begin
                checks++;
                if (wb_sel !== 2'd0) begin errors++; $display("[TB] FAIL rtype_wb_sel: got %0d expected 0", wb_sel); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        int memSeen = 0;
        int reqHigh = 0;
        bit weSeen  = 0;
        bit sawWb   = 0;
        do_reset();
        instr = 32'h0000A103; imem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sawWb) break;
            dmem_ready = (memSeen == 3);
            @(negedge clk);
            if (dmem_req === 1'b1) reqHigh++;
            if (dmem_we === 1'b1) weSeen = 1;
            if (state === ST_MEM) memSeen++;
            if (state === ST_WB) begin
                sawWb = 1;
                checks++;
                if (wb_sel !== 2'd1 || reg_we !== 1'b1)
                    begin errors++; $display("[TB] FAIL load_wb: wb_sel=%0d reg_we=%b expected 1 1", wb_sel, reg_we); end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (sawWb !== 1'b1) begin errors++; $display("[TB] FAIL load_reach_wb: got %b expected 1 within 20 cycles", sawWb); end
        checks++;
        if (reqHigh != 4) begin errors++; $display("[TB] FAIL load_dmem_req_cycles: got %0d expected 4", reqHigh); end
        checks++;
        if (weSeen !== 1'b0) begin errors++; $display("[TB] FAIL load_dmem_we: got %b expected 0", weSeen); end
    endtask

    task automatic test_branch();
        for (int tk = 0; tk < 2; tk++) begin
            do_reset();
            instr = 32'h00208463; imem_ready = 1'b1; branch_taken = 1'(tk);
            @(posedge clk); #1;
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (state !== ST_EXECUTE || pc_we !== 1'(tk) || pc_sel !== ((tk == 1) ? 2'd1 : 2'd0) || alu_op !== 2'd1)
                begin errors++; $display("[TB] FAIL branch_exec_taken%0d: state=%0d pc_we=%b pc_sel=%0d alu_op=%0d expected 2 %0d %0d 1", tk, state, pc_we, pc_sel, alu_op, tk, tk); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (state !== ST_FETCH) begin errors++; $display("[TB] FAIL branch_return_taken%0d: state=%0d expected 0", tk, state); end
        end
    endtask

    task automatic test_illegal();
        outs_t e;
        e = '0; e.st = ST_TRAP; e.trp = 1'b1;
        do_reset();
        instr = 32'h0000007F; imem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== e) begin errors++; $display("[TB] FAIL illegal_trap_cycle%0d: got %h expected %h", i, obs(), e); end
            @(posedge clk); #1;
            instr = 32'h002081B3; imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom); branch_taken = 1'($urandom);
        end
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if (state !== ST_FETCH || trap !== 1'b0)
            begin errors++; $display("[TB] FAIL illegal_reset_clears: state=%0d trap=%b expected 0 0", state, trap); end
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    task automatic test_timeout();
        do_reset();
        instr = 32'h002081B3;
        for (int i = 0; i <= TO; i++) begin
            imem_ready = (i == TO);
            @(negedge clk);
            checks++;
            if (state !== ST_FETCH || imem_req !== 1'b1 || ir_we !== imem_ready)
                begin errors++; $display("[TB] FAIL timeout_edge_wait%0d: state=%0d imem_req=%b ir_we=%b expected 0 1 %b", i, state, imem_req, ir_we, imem_ready); end
            @(posedge clk); #1;
        end
        imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== ST_DECODE || trap !== 1'b0)
            begin errors++; $display("[TB] FAIL timeout_edge_decode: state=%0d trap=%b expected 1 0", state, trap); end
        do_reset();
        for (int i = 0; i <= TO; i++) begin
            @(negedge clk);
            checks++;
            if (state !== ST_FETCH || imem_req !== 1'b1)
                begin errors++; $display("[TB] FAIL timeout_wait%0d: state=%0d imem_req=%b expected 0 1", i, state, imem_req); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (state !== ST_TRAP || trap !== 1'b1 || imem_req !== 1'b0)
            begin errors++; $display("[TB] FAIL timeout_trap: state=%0d trap=%b imem_req=%b expected 5 1 0", state, trap, imem_req); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        instr = 32'h0000A103; imem_ready = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (state !== ST_MEM || dmem_req !== 1'b1)
            begin errors++; $display("[TB] FAIL midmem_in_mem: state=%0d dmem_req=%b expected 3 1", state, dmem_req); end
        n_rst = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || state !== ST_FETCH)
            begin errors++; $display("[TB] FAIL midmem_reset_drop: dmem_req=%b state=%0d expected 0 0", dmem_req, state); end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || state !== ST_FETCH)
            begin errors++; $display("[TB] FAIL midmem_first_fetch: imem_req=%b state=%0d expected 1 0", imem_req, state); end
    endtask

    task automatic test_random();
        int          c, fd, md;
        logic        taken;
        logic [31:0] ins;
        cyc_t        cy;
        do_reset();
        for (int t = 0; t < 150; t++) begin
            c     = int'($urandom_range(0, 7));
            fd    = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 3));
            md    = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 3));
            taken = 1'($urandom);
            ins   = $urandom;
            ins[6:0] = model_opc(c);
            trace.delete();
            model_instr(c, ins, fd, md, taken);
            while (trace.size() > 0) begin
                cy = trace.pop_front();
                instr = cy.ins; imem_ready = cy.ir; dmem_ready = cy.dr; branch_taken = cy.bt;
                @(negedge clk);
                checks++;
                if (obs() !== cy.exp)
                    begin errors++; $display("[TB] FAIL random_t%0d_cls%0d: got %h expected %h", t, c, obs(), cy.exp); end
                @(posedge clk); #1;
            end
        end
    endtask

    // Absolute guard so a stuck run still ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_rst = 1'b0; instr = '0;
        imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
